poll_scheduler: RTL and testbench
=================================

Name: poll_scheduler

Overview:
- Sits between cmd_decoder and the slave interfaces (SPI potentiometers, ADCs, DDS, fpga_regs, func_testing, keep_alive).
- Merges host command bytes with autonomously generated periodic poll commands, e.g. ADC conversion reads, onto one master_data/valid_bus pair.
- Packets from the two sources are never interleaved. Host and poll packets alternate fairly.
- Slave responses return through cmd_encoder unchanged.

Parameters:
N_SRC, 24, number of slave addresses (width of valid buses)
N_POLL, 4, number of poll table entries
PERIOD_W, 24, width of poll period counters (cycles of clk)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
host_data  in  8  command byte from cmd_decoder
host_valid_bus  in  N_SRC  one-hot strobe, target address of host_data
host_last  in  1  qualifies final byte of a host packet
host_ready  out  1  byte accepted when |host_valid_bus && host_ready
cfg_wr  in  1  poll table write strobe
cfg_idx  in  $clog2(N_POLL)  entry index
cfg_en  in  1  entry enable
cfg_addr  in  5  slave address for entry
cfg_two  in  1  0: 1 payload byte, 1: 2 payload bytes
cfg_bytes  in  16  payload: [15:8] first byte, [7:0] second byte
cfg_period  in  PERIOD_W  poll period in cycles; 0 = entry inactive
master_data  out  8  byte to slaves
valid_bus  out  N_SRC  one-hot byte strobe to slaves
poll_overrun  out  N_POLL  sticky per entry; cleared by cfg write to that entry

Behaviour:
- Reset (sync, rst=1 at clk edge): all entries disabled, counters 0, pending 0, state IDLE, master_data=0, valid_bus=0, poll_overrun=0, rr pointer=0, turn=HOST.
- Outputs are registered. Latency is 1 cycle: an accepted host byte appears on master_data/valid_bus the next cycle.
- valid_bus is 0 whenever no byte is issued. master_data holds its last value.
- host_ready is combinational from registers only: 1 in HOST; 1 in IDLE unless (turn==POLL && any pending); 0 otherwise.
- Per entry, active = en && period!=0 && addr<N_SRC:
  - Down-counter decrements every cycle. At 0 it reloads period-1 and sets pending.
  - If already pending at expiry, set poll_overrun[i]. No second request is queued.
- cfg_wr:
  - Writes the entry, loads counter=period-1, clears pending and poll_overrun[i].
  - cfg_addr>=N_SRC forces en=0.
  - A write to the entry currently being injected does not disturb the injection, because payload is latched at injection start.
- State IDLE:
  - Host byte accepted and turn==HOST (or nothing pending): issue byte. Go to IDLE if host_last, else HOST.
  - Else, any pending: select the lowest pending index at or after rr (wrap-around). Latch addr/bytes/two, clear its pending, go to POLL_B0.
  - Simultaneous host byte and pending with turn==POLL: the poll wins; host_ready is already 0.
- State HOST: issue each accepted byte. host_last returns to IDLE and sets turn=POLL. Cycles with no host byte simply wait; there is no timeout.
- State POLL_B0: issue first byte to addr. Go to POLL_B1 if two, else IDLE.
- State POLL_B1: issue second byte, go to IDLE.
- After any poll completes: rr=sel+1 mod N_POLL, turn=HOST.
- A poll packet occupies valid_bus on consecutive cycles, 1 or 2 bytes, no gaps.
- turn only matters when both sources want service. With no host traffic, polls run back-to-back.
- Pending set and injection-clear in the same cycle for the same entry: set wins, so the entry is re-pending.
- rst during any state: immediate return to reset values. A partial packet is abandoned and valid_bus=0 the next cycle.

Optional Feature:
- Macro POLL_SCHED_STATS_EN.
- Defined: adds output poll_count (8*N_POLL bits), a per-entry 8-bit saturating count of injected polls (stops at 255), cleared by rst or a cfg write to that entry.
- Undefined: port and counters absent. All other behaviour is identical.

Test Plan:
- Entry0: addr=4, two=1, bytes=0xA50B, period=10, written at cycle 0, no host traffic -> valid_bus[4] with 0xA5 then 0x0B on consecutive cycles, repeating every 10 cycles. poll_overrun=0.
- Host packet to addr 8 (bytes 0x01,0x02,0x03, last on 3rd) while entry0 becomes pending mid-packet -> all 3 host bytes on valid_bus[8] uninterrupted, host_ready=0 for the poll, poll bytes follow immediately, then host_ready=1.
- Entries 0,1,2 (addrs 4,5,6, one byte each) pending simultaneously, rr=0 -> injection order 4,5,6. A subsequent tie starts at the entry after the last served.
- Continuous host traffic, addr 0x16 single-byte packets, plus entry period=3 -> strict alternation host/poll. Overrun flag set because the poll cannot keep up; a cfg write clears it.
- cfg_addr=30 or cfg_period=0 -> entry never injects. rst asserted during POLL_B0 -> valid_bus=0 next cycle, pending cleared, no POLL_B1.
- With POLL_SCHED_STATS_EN: 300 polls on entry0 -> poll_count[7:0]=255.

Source files
------------

// File: rtl/poll_scheduler.sv
// Merges host command packets with periodic poll packets onto one master_data/valid_bus pair, 1-cycle latency, no interleave.
// `define POLL_SCHED_STATS_EN adds poll_count: per-entry 8-bit saturating count of injected polls.
module poll_scheduler #(
  parameter int  N_SRC    = 24,
  parameter int  N_POLL   = 4,
  parameter int  PERIOD_W = 24,
  localparam int IDX_W    = $clog2(N_POLL)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          host_data,
  input  logic [N_SRC-1:0]    host_valid_bus,
  input  logic                host_last,
  output logic                host_ready,
  input  logic                cfg_wr,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic                cfg_en,
  input  logic [4:0]          cfg_addr,
  input  logic                cfg_two,
  input  logic [15:0]         cfg_bytes,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [7:0]          master_data,
  output logic [N_SRC-1:0]    valid_bus,
  output logic [N_POLL-1:0]   poll_overrun
`ifdef POLL_SCHED_STATS_EN
  ,
  output logic [8*N_POLL-1:0] poll_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_HOST, S_POLL_B0, S_POLL_B1} state_t;

  state_t             state_q;
  logic               turn_poll_q;
  logic [IDX_W-1:0]   rr_q, rr_next, lat_idx_q, sel_idx, cand;
  logic               sel_vld;
  logic [4:0]         lat_addr_q;
  logic               lat_two_q;
  logic [15:0]        lat_bytes_q;
  logic [7:0]         master_data_q;
  logic [N_SRC-1:0]   valid_bus_q;

  logic               en_q     [N_POLL];
  logic [4:0]         addr_q   [N_POLL];
  logic               two_q    [N_POLL];
  logic [15:0]        bytes_q  [N_POLL];
  logic [PERIOD_W-1:0] period_q [N_POLL];
  logic [PERIOD_W-1:0] cnt_q    [N_POLL];
  logic [N_POLL-1:0]  pend_q, ovr_q;

  logic               host_acc, inject;

  assign host_ready   = (state_q == S_HOST) ||
                        (state_q == S_IDLE && !(turn_poll_q && (|pend_q)));
  assign host_acc     = (|host_valid_bus) && host_ready;
  assign inject       = (state_q == S_IDLE) && !host_acc && sel_vld;
  assign rr_next      = (lat_idx_q == IDX_W'(N_POLL - 1)) ? '0 : lat_idx_q + IDX_W'(1);
  assign master_data  = master_data_q;
  assign valid_bus    = valid_bus_q;
  assign poll_overrun = ovr_q;

  // Round-robin pick: scan from rr downwards in distance so the nearest pending entry wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = N_POLL - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % N_POLL);
      if (pend_q[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      turn_poll_q   <= 1'b0;
      rr_q          <= '0;
      lat_idx_q     <= '0;
      lat_addr_q    <= '0;
      lat_two_q     <= 1'b0;
      lat_bytes_q   <= '0;
      master_data_q <= '0;
      valid_bus_q   <= '0;
    end else begin
      valid_bus_q <= '0;
      case (state_q)
        S_IDLE, S_HOST: begin
          if (host_acc) begin
            master_data_q <= host_data;
            valid_bus_q   <= host_valid_bus;
            state_q       <= host_last ? S_IDLE : S_HOST;
            if (host_last) turn_poll_q <= 1'b1;
          end else if (inject) begin
            lat_idx_q   <= sel_idx;
            lat_addr_q  <= addr_q[sel_idx];
            lat_two_q   <= two_q[sel_idx];
            lat_bytes_q <= bytes_q[sel_idx];
            state_q     <= S_POLL_B0;
          end
        end
        S_POLL_B0: begin
          master_data_q <= lat_bytes_q[15:8];
          valid_bus_q   <= N_SRC'(1) << lat_addr_q;
          if (lat_two_q) begin
            state_q <= S_POLL_B1;
          end else begin
            state_q     <= S_IDLE;
            rr_q        <= rr_next;
            turn_poll_q <= 1'b0;
          end
        end
        S_POLL_B1: begin
          master_data_q <= lat_bytes_q[7:0];
          valid_bus_q   <= N_SRC'(1) << lat_addr_q;
          state_q       <= S_IDLE;
          rr_q          <= rr_next;
          turn_poll_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Later assignments override the injection clear: a cfg write or a fresh expiry wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_POLL; i++) begin
        en_q[i]     <= 1'b0;
        addr_q[i]   <= '0;
        two_q[i]    <= 1'b0;
        bytes_q[i]  <= '0;
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      for (int i = 0; i < N_POLL; i++) begin
        if (inject && sel_idx == IDX_W'(i)) pend_q[i] <= 1'b0;
        if (cfg_wr && cfg_idx == IDX_W'(i)) begin
          en_q[i]     <= cfg_en && (int'(cfg_addr) < N_SRC);
          addr_q[i]   <= cfg_addr;
          two_q[i]    <= cfg_two;
          bytes_q[i]  <= cfg_bytes;
          period_q[i] <= cfg_period;
          cnt_q[i]    <= cfg_period - PERIOD_W'(1);
          pend_q[i]   <= 1'b0;
          ovr_q[i]    <= 1'b0;
        end else if (en_q[i] && period_q[i] != '0) begin
          if (cnt_q[i] == '0) begin
            cnt_q[i]  <= period_q[i] - PERIOD_W'(1);
            pend_q[i] <= 1'b1;
            if (pend_q[i]) ovr_q[i] <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] - PERIOD_W'(1);
          end
        end
      end
    end
  end

`ifdef POLL_SCHED_STATS_EN
  logic [7:0] stat_q [N_POLL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_POLL; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_POLL; i++) begin
        if (inject && sel_idx == IDX_W'(i) && stat_q[i] != 8'hFF) stat_q[i] <= stat_q[i] + 8'd1;
        if (cfg_wr && cfg_idx == IDX_W'(i)) stat_q[i] <= '0;
      end
    end
  end

  for (genvar g = 0; g < N_POLL; g++) begin : g_stat
    assign poll_count[8*g +: 8] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_poll_scheduler.sv
// Randomized bench for poll_scheduler against a byte-queue reference model of the scheduling rules.
module tb_poll_scheduler;
  localparam int N_SRC = 24;
  localparam int N_POLL = 4;
  localparam int PW = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        host_data;
  logic [N_SRC-1:0]  host_valid_bus;
  logic              host_last;
  logic              host_ready;
  logic              cfg_wr;
  logic [1:0]        cfg_idx;
  logic              cfg_en;
  logic [4:0]        cfg_addr;
  logic              cfg_two;
  logic [15:0]       cfg_bytes;
  logic [PW-1:0]     cfg_period;
  logic [7:0]        master_data;
  logic [N_SRC-1:0]  valid_bus;
  logic [N_POLL-1:0] poll_overrun;
  logic [8*N_POLL-1:0] poll_count;

  always #5 clk = ~clk;

  poll_scheduler #(.N_SRC(N_SRC), .N_POLL(N_POLL), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst),
    .host_data(host_data), .host_valid_bus(host_valid_bus), .host_last(host_last), .host_ready(host_ready),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_addr(cfg_addr), .cfg_two(cfg_two),
    .cfg_bytes(cfg_bytes), .cfg_period(cfg_period),
    .master_data(master_data), .valid_bus(valid_bus), .poll_overrun(poll_overrun)
`ifdef POLL_SCHED_STATS_EN
    , .poll_count(poll_count)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Host source: flattened byte queue, popped when the model says the byte was taken.
  typedef struct { int addr; int data; bit last; } hbyte_t;
  hbyte_t hq[$];
  int     gap_pct = 0;
  bit     host_taken;

  // Reference model: table as plain ints, an in-flight poll as a queue of bytes still to send.
  bit m_en[N_POLL];  int m_addr[N_POLL]; bit m_two[N_POLL]; int m_bytes[N_POLL];
  int m_per[N_POLL]; int m_cnt[N_POLL];  bit m_pend[N_POLL]; bit m_ovr[N_POLL]; int m_stat[N_POLL];
  int m_rr, m_sel;
  bit m_turn_poll, m_in_host;
  int pq_addr[$], pq_dat[$];
  logic [N_SRC-1:0] e_vb;
  logic [7:0]       e_md;

  function automatic bit m_ready();
    bit any = 0;
    for (int i = 0; i < N_POLL; i++) any |= m_pend[i];
    if (pq_addr.size() > 0) return 0;
    if (m_in_host) return 1;
    return !(m_turn_poll && any);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_POLL; i++) begin
      m_en[i] = 0; m_addr[i] = 0; m_two[i] = 0; m_bytes[i] = 0;
      m_per[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_ovr[i] = 0; m_stat[i] = 0;
    end
    m_rr = 0; m_sel = 0; m_turn_poll = 0; m_in_host = 0;
    pq_addr.delete(); pq_dat.delete();
    e_vb = '0; e_md = '0;
  endtask

  task automatic m_step();
    bit any = 0;
    bit acc, old;
    int sel = -1;
    host_taken = 0;
    if (rst) begin m_reset(); return; end
    for (int i = 0; i < N_POLL; i++) any |= m_pend[i];
    acc = (host_valid_bus != 0) && m_ready();
    e_vb = '0;
    if (pq_addr.size() > 0) begin
      e_vb = N_SRC'(1) << pq_addr[0];
      e_md = 8'(pq_dat[0]);
      void'(pq_addr.pop_front()); void'(pq_dat.pop_front());
      if (pq_addr.size() == 0) begin m_rr = (m_sel + 1) % N_POLL; m_turn_poll = 0; end
    end else if (acc) begin
      e_vb = host_valid_bus; e_md = host_data;
      m_in_host = !host_last;
      if (host_last) m_turn_poll = 1;
      host_taken = 1;
    end else if (!m_in_host && any) begin
      for (int k = 0; k < N_POLL; k++)
        if (m_pend[(m_rr + k) % N_POLL]) begin sel = (m_rr + k) % N_POLL; break; end
      m_sel = sel;
      pq_addr.push_back(m_addr[sel]); pq_dat.push_back(m_bytes[sel] >> 8);
      if (m_two[sel]) begin pq_addr.push_back(m_addr[sel]); pq_dat.push_back(m_bytes[sel] & 255); end
    end
    for (int i = 0; i < N_POLL; i++) begin
      old = m_pend[i];
      if (sel == i) begin m_pend[i] = 0; if (m_stat[i] < 255) m_stat[i]++; end
      if (cfg_wr && cfg_idx == i) begin
        m_en[i] = cfg_en; m_addr[i] = cfg_addr; m_two[i] = cfg_two; m_bytes[i] = cfg_bytes;
        m_per[i] = cfg_period; m_cnt[i] = (int'(cfg_period) - 1) & 24'hFFFFFF;
        m_pend[i] = 0; m_ovr[i] = 0; m_stat[i] = 0;
      end else if (m_en[i] && m_per[i] != 0 && m_addr[i] < N_SRC) begin
        if (m_cnt[i] == 0) begin
          m_cnt[i] = m_per[i] - 1; m_pend[i] = 1;
          if (old) m_ovr[i] = 1;
        end else m_cnt[i]--;
      end
    end
  endtask

  task automatic cycle();
    logic [N_POLL-1:0]   e_ovr;
    logic [8*N_POLL-1:0] e_pc;
    if (hq.size() > 0 && $urandom_range(99) >= gap_pct) begin
      host_valid_bus = N_SRC'(1) << hq[0].addr;
      host_data = 8'(hq[0].data);
      host_last = hq[0].last;
    end else begin
      host_valid_bus = '0;
      host_data = 8'($urandom);
      host_last = 1'($urandom);
    end
    @(posedge clk);
    m_step();
    if (rst) hq.delete();
    else if (host_taken) void'(hq.pop_front());
    #1;
    for (int i = 0; i < N_POLL; i++) begin
      e_ovr[i] = m_ovr[i];
      e_pc[8*i +: 8] = 8'(m_stat[i]);
    end
    chk("valid_bus", valid_bus, e_vb);
    chk("master_data", master_data, e_md);
    chk("host_ready", host_ready, m_ready());
    chk("poll_overrun", poll_overrun, e_ovr);
`ifdef POLL_SCHED_STATS_EN
    chk("poll_count", poll_count, e_pc);
`endif
    rst = 0;
    cfg_wr = 0;
  endtask

  task automatic cfg(input int idx, input bit en, input int addr, input bit two, input int bytes, input int per);
    cfg_wr = 1; cfg_idx = 2'(idx); cfg_en = en; cfg_addr = 5'(addr);
    cfg_two = two; cfg_bytes = 16'(bytes); cfg_period = PW'(per);
    cycle();
  endtask

  task automatic push_pkt(input int addr, input int n);
    for (int j = 0; j < n; j++) hq.push_back('{addr, int'($urandom_range(255)), j == n - 1});
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
  endtask

  int n, obs[$];
  bit reached;

  initial begin
    rst = 1; cfg_wr = 0; cfg_idx = 0; cfg_en = 0; cfg_addr = 0; cfg_two = 0; cfg_bytes = 0; cfg_period = 0;
    host_data = 0; host_valid_bus = 0; host_last = 0;
    m_reset();
    do_reset();
    chk("rst_host_ready", host_ready, 1);
    chk("rst_valid_bus", valid_bus, 0);

    // Periodic 2-byte poll, no host traffic: 5 polls (10 bytes) within 60 cycles of the write.
    cfg(0, 1, 4, 1, 'hA50B, 10);
    n = 0;
    repeat (60) begin cycle(); if (valid_bus[4]) n++; end
    chk("s1_poll_bytes", n, 10);

    // 3-byte host packets to addr 8 at shifting phases against the pending poll.
    repeat (10) begin
      hq.push_back('{8, 1, 0}); hq.push_back('{8, 2, 0}); hq.push_back('{8, 3, 1});
      repeat (13) cycle();
    end

    // Three entries expiring on the same edge: served in index order from rr=0.
    do_reset();
    cfg(0, 1, 4, 0, 'h4100, 12);
    cfg(1, 1, 5, 0, 'h5100, 11);
    cfg(2, 1, 6, 0, 'h6100, 10);
    obs.delete();
    repeat (80) begin cycle(); if (valid_bus != 0) obs.push_back($clog2(valid_bus)); end
    chk("s3_order0", obs.size() > 0 ? obs[0] : -1, 4);
    chk("s3_order1", obs.size() > 1 ? obs[1] : -1, 5);
    chk("s3_order2", obs.size() > 2 ? obs[2] : -1, 6);

    // Continuous single-byte host packets vs fast poll: alternation, overrun, cleared by cfg write.
    do_reset();
    cfg(0, 1, 4, 0, 'h7700, 2);
    repeat (40) begin
      while (hq.size() < 2) push_pkt(5'h16, 1);
      cycle();
    end
    chk("s4_overrun_set", poll_overrun[0], 1);
    cfg(0, 1, 4, 0, 'h7700, 2);
    chk("s4_overrun_clr", poll_overrun[0], 0);
    hq.delete();

    // Out-of-range address, zero period and disabled entries never inject.
    do_reset();
    cfg(1, 1, 30, 0, 'h1100, 5);
    cfg(2, 1, 3, 0, 'h2200, 0);
    cfg(3, 0, 7, 1, 'h3300, 4);
    n = 0;
    repeat (40) begin cycle(); if (valid_bus != 0) n++; end
    chk("s5_quiet", n, 0);

    // Reset while the first poll byte is about to go out.
    do_reset();
    cfg(0, 1, 9, 1, 'h1234, 4);
    reached = 0;
    for (int c = 0; c < 30 && !reached; c++) begin
      cycle();
      if (pq_addr.size() == 2) reached = 1;
    end
    chk("s6_reach_b0", reached, 1);
    do_reset();
    chk("s6_vb_after_rst", valid_bus, 0);
    repeat (5) cycle();

    // Random mix of cfg writes, host packets, gaps and occasional resets.
    do_reset();
    gap_pct = 30;
    repeat (2500) begin
      if ($urandom_range(99) < 5)
        cfg($urandom_range(3), $urandom_range(3) != 0, $urandom_range(31), 1'($urandom),
            $urandom_range(16'hFFFF), $urandom_range(14));
      else begin
        if ($urandom_range(99) < 8 && hq.size() < 6) push_pkt($urandom_range(N_SRC - 1), $urandom_range(1, 4));
        if ($urandom_range(999) < 3) rst = 1;
        cycle();
      end
    end
    gap_pct = 0;
    hq.delete();

`ifdef POLL_SCHED_STATS_EN
    do_reset();
    cfg(0, 1, 4, 0, 'h5500, 1);
    repeat (700) cycle();
    chk("stat_saturate", poll_count[7:0], 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
